// File: rtl/lpc_pkg.sv
// Shared LPC definitions: predictor order, Q-formats, sample limits and the synthesis FSM encoding.
package lpc_pkg;

  localparam int LPC_ORDER = 10;
  localparam int COEF_FRAC = 12;
  localparam int COEF_W    = 16;
  localparam int SAMPLE_W  = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W     = 40;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Peak sample limits, shared with the encoder's level detector
  localparam int PEAK_POS = 32767;
  localparam int PEAK_NEG = -32768;

  localparam longint ROUND_HALF = 64'sd1 <<< (COEF_FRAC - 1);

  // De-emphasis pole of 0.9375 in Q0.15
  localparam logic signed [15:0] DEEMPH_COEF  = 16'sd30720;
  localparam int                 DEEMPH_SHIFT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXC,
    ST_MAC,
    ST_SAT,
    ST_DEEMPH,
    ST_OUT
  } synth_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > ACC_W'(PEAK_POS))
      r = SAMPLE_W'(PEAK_POS);
    else if (v < ACC_W'(PEAK_NEG))
      r = SAMPLE_W'(PEAK_NEG);
    else
      r = v[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/lpc_excitation.sv
// Excitation source: pitch-period pulse train when voiced, scaled LFSR noise otherwise.
module lpc_excitation
  import lpc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic                       voiced,
  input  logic [15:0]                pitch,
  input  logic [15:0]                gain,
  output logic signed [SAMPLE_W-1:0] e
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        was_pulse_q, was_pulse_d;
  logic        pulse_mode;
  logic [15:0] pc_eff;
  logic signed [SAMPLE_W-1:0] noise_amp;
  logic        feedback;

  always_comb begin
    pc_d        = pc_q;
    lfsr_d      = lfsr_q;
    was_pulse_d = was_pulse_q;
    e           = '0;
    pulse_mode  = voiced && (pitch != 16'd0);
    // Entering pulse mode from noise fires a pulse straight away
    pc_eff      = was_pulse_q ? pc_q : 16'd0;
    noise_amp   = $signed({2'b00, gain[15:2]});
    feedback    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    if (pulse_mode) begin
      if (pc_eff == 16'd0) begin
        e = $signed(gain);
        if (step) pc_d = pitch - 16'd1;
      end else begin
        if (step) pc_d = pc_eff - 16'd1;
      end
    end else begin
      e = lfsr_q[0] ? noise_amp : -noise_amp;
      if (step) lfsr_d = {feedback, lfsr_q[15:1]};
    end

    if (step) was_pulse_d = pulse_mode;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= '0;
      lfsr_q      <= LFSR_SEED;
      was_pulse_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      lfsr_q      <= lfsr_d;
      was_pulse_q <= was_pulse_d;
    end
  end

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis filter: single time-multiplexed MAC all-pole filter driven by lpc_excitation.
// Define LPC_SYNTH_DEEMPH_EN to add a one-cycle de-emphasis stage before the output.
module lpc_synth
  import lpc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_v,
  input  logic signed [COEF_W-1:0]   A1,
  input  logic signed [COEF_W-1:0]   A2,
  input  logic signed [COEF_W-1:0]   A3,
  input  logic signed [COEF_W-1:0]   A4,
  input  logic signed [COEF_W-1:0]   A5,
  input  logic signed [COEF_W-1:0]   A6,
  input  logic signed [COEF_W-1:0]   A7,
  input  logic signed [COEF_W-1:0]   A8,
  input  logic signed [COEF_W-1:0]   A9,
  input  logic signed [COEF_W-1:0]   A10,
  input  logic                       voiced,
  input  logic [15:0]                pitch,
  input  logic [15:0]                gain,
  input  logic                       sample_en,
  output logic signed [SAMPLE_W-1:0] y,
  output logic                       y_v,
  output logic                       busy,
  output logic                       overrun
);

  synth_state_t state_q, state_d;

  logic signed [COEF_W-1:0]   coef_in [LPC_ORDER];
  logic signed [COEF_W-1:0]   sh_a_q [LPC_ORDER];
  logic signed [COEF_W-1:0]   sh_a_d [LPC_ORDER];
  logic signed [COEF_W-1:0]   wk_a_q [LPC_ORDER];
  logic signed [COEF_W-1:0]   wk_a_d [LPC_ORDER];
  logic                       sh_voiced_q, sh_voiced_d, wk_voiced_q, wk_voiced_d;
  logic [15:0]                sh_pitch_q, sh_pitch_d, wk_pitch_q, wk_pitch_d;
  logic [15:0]                sh_gain_q, sh_gain_d, wk_gain_q, wk_gain_d;
  logic signed [SAMPLE_W-1:0] hist_q [LPC_ORDER];
  logic signed [SAMPLE_W-1:0] hist_d [LPC_ORDER];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [3:0]                 k_q, k_d;
  logic signed [SAMPLE_W-1:0] y_q, y_d;
  logic                       overrun_q, overrun_d;

  logic                       exc_step;
  logic signed [SAMPLE_W-1:0] e;
  logic [3:0]                 idx;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    rounded;
  logic signed [SAMPLE_W-1:0] s;

`ifdef LPC_SYNTH_DEEMPH_EN
  logic signed [SAMPLE_W-1:0] d_prev_q, d_prev_d;
  logic signed [PROD_W-1:0]   d_prod;
  logic signed [ACC_W-1:0]    d_sum;
`endif

  assign coef_in = '{A1, A2, A3, A4, A5, A6, A7, A8, A9, A10};
  assign exc_step = (state_q == ST_EXC);

  lpc_excitation u_exc (
    .clk    (clk),
    .rst    (rst),
    .step   (exc_step),
    .voiced (wk_voiced_q),
    .pitch  (wk_pitch_q),
    .gain   (wk_gain_q),
    .e      (e)
  );

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    wk_a_d      = wk_a_q;
    sh_voiced_d = sh_voiced_q;
    wk_voiced_d = wk_voiced_q;
    sh_pitch_d  = sh_pitch_q;
    wk_pitch_d  = wk_pitch_q;
    sh_gain_d   = sh_gain_q;
    wk_gain_d   = wk_gain_q;
    hist_d      = hist_q;
    acc_d       = acc_q;
    k_d         = k_q;
    y_d         = y_q;
    overrun_d   = overrun_q;
    idx         = k_q - 4'd1;
    prod        = wk_a_q[idx] * hist_q[idx];
    rounded     = acc_q + ACC_W'(ROUND_HALF);
    s           = sat16(rounded >>> COEF_FRAC);
`ifdef LPC_SYNTH_DEEMPH_EN
    d_prev_d    = d_prev_q;
    d_prod      = DEEMPH_COEF * d_prev_q;
    d_sum       = ACC_W'(acc_q[SAMPLE_W-1:0]) + ACC_W'(d_prod >>> DEEMPH_SHIFT);
`endif

    if (frame_v) begin
      sh_a_d      = coef_in;
      sh_voiced_d = voiced;
      sh_pitch_d  = pitch;
      sh_gain_d   = gain;
    end

    if (sample_en && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Working set is frozen here so a mid-sample frame_v only affects the next sample
        if (sample_en) begin
          wk_a_d      = sh_a_q;
          wk_voiced_d = sh_voiced_q;
          wk_pitch_d  = sh_pitch_q;
          wk_gain_d   = sh_gain_q;
          state_d     = ST_EXC;
        end
      end
      ST_EXC: begin
        acc_d   = ACC_W'(e) <<< COEF_FRAC;
        k_d     = 4'd1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_q - ACC_W'(prod);
        k_d   = k_q + 4'd1;
        if (k_q == 4'(LPC_ORDER)) state_d = ST_SAT;
      end
      ST_SAT: begin
        hist_d[0] = s;
        for (int i = 1; i < LPC_ORDER; i++) hist_d[i] = hist_q[i-1];
`ifdef LPC_SYNTH_DEEMPH_EN
        acc_d   = ACC_W'(s);
        state_d = ST_DEEMPH;
`else
        y_d     = s;
        state_d = ST_OUT;
`endif
      end
      ST_DEEMPH: begin
`ifdef LPC_SYNTH_DEEMPH_EN
        y_d      = sat16(d_sum);
        d_prev_d = sat16(d_sum);
`endif
        state_d = ST_OUT;
      end
      ST_OUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '{default: '0};
      wk_a_q      <= '{default: '0};
      sh_voiced_q <= 1'b0;
      wk_voiced_q <= 1'b0;
      sh_pitch_q  <= '0;
      wk_pitch_q  <= '0;
      sh_gain_q   <= '0;
      wk_gain_q   <= '0;
      hist_q      <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      y_q         <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      wk_a_q      <= wk_a_d;
      sh_voiced_q <= sh_voiced_d;
      wk_voiced_q <= wk_voiced_d;
      sh_pitch_q  <= sh_pitch_d;
      wk_pitch_q  <= wk_pitch_d;
      sh_gain_q   <= sh_gain_d;
      wk_gain_q   <= wk_gain_d;
      hist_q      <= hist_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      y_q         <= y_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef LPC_SYNTH_DEEMPH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_prev_q <= '0;
    else      d_prev_q <= d_prev_d;
  end
`endif

  assign y       = y_q;
  assign y_v     = (state_q == ST_OUT);
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_lpc_synth.sv
// Directed self-checking bench for lpc_synth (default build, latency ORDER+3).
module tb_lpc_synth;

  localparam int LAT     = 13;
  localparam int TIMEOUT = 40;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_v = 1'b0;
  logic signed [15:0] a_tb [10];
  logic               voiced_tb = 1'b0;
  logic [15:0]        pitch_tb = '0;
  logic [15:0]        gain_tb = '0;
  logic               sample_en = 1'b0;
  logic signed [15:0] y;
  logic               y_v;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lpc_synth dut (
    .clk       (clk),
    .rst       (rst),
    .frame_v   (frame_v),
    .A1        (a_tb[0]),
    .A2        (a_tb[1]),
    .A3        (a_tb[2]),
    .A4        (a_tb[3]),
    .A5        (a_tb[4]),
    .A6        (a_tb[5]),
    .A7        (a_tb[6]),
    .A8        (a_tb[7]),
    .A9        (a_tb[8]),
    .A10       (a_tb[9]),
    .voiced    (voiced_tb),
    .pitch     (pitch_tb),
    .gain      (gain_tb),
    .sample_en (sample_en),
    .y         (y),
    .y_v       (y_v),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic apply_frame(input int a1, input logic v, input int p, input int g);
    for (int i = 0; i < 10; i++) a_tb[i] = '0;
    a_tb[0]   = 16'(a1);
    voiced_tb = v;
    pitch_tb  = 16'(p);
    gain_tb   = 16'(g);
    frame_v   = 1'b1;
    tick();
    frame_v   = 1'b0;
  endtask

  task automatic wait_y(output int yv, output int lat);
    lat = 1;
    while (!y_v && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    check_output("y_v_seen", int'(y_v), 1);
    yv = int'(y);
    tick();
  endtask

  task automatic apply_sample(output int yv, output int lat);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    wait_y(yv, lat);
  endtask

  initial begin
    int yv, lat, cnt, ycyc;
    int exp1 [12];
    int exp2 [13];
    logic [15:0] lfsr;

    exp1 = '{1000, 0, 0, 0, 1000, 0, 0, 0, 1000, 0, 0, 0};
    exp2 = '{1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 1};
    for (int i = 0; i < 10; i++) a_tb[i] = '0;

    tick();
    check_output("reset_y", int'(y), 0);
    check_output("reset_y_v", int'(y_v), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    tick();

    $display("[TB] pulse train, A=0, pitch 4");
    apply_frame(0, 1'b1, 4, 1000);
    for (int n = 0; n < 12; n++) begin
      apply_sample(yv, lat);
      check_output($sformatf("pulse_y%0d", n), yv, exp1[n]);
      if (n == 0) check_output("latency", lat, LAT);
    end

    $display("[TB] one-pole decay, A1=-0.5");
    apply_reset();
    apply_frame(-2048, 1'b1, 100, 1024);
    for (int n = 0; n < 13; n++) begin
      apply_sample(yv, lat);
      check_output($sformatf("decay_y%0d", n), yv, exp2[n]);
    end

    $display("[TB] saturation, A1=-1.0");
    apply_reset();
    apply_frame(-4096, 1'b1, 1, 30000);
    for (int n = 0; n < 4; n++) begin
      apply_sample(yv, lat);
      check_output($sformatf("sat_y%0d", n), yv, (n == 0) ? 30000 : 32767);
    end

    $display("[TB] overrun");
    apply_reset();
    apply_frame(0, 1'b1, 4, 500);
    sample_en = 1'b1;
    tick();
    cnt  = 0;
    ycyc = -1;
    for (int c = 1; c <= 20; c++) begin
      sample_en = (c == 5);
      if (c == 3) check_output("busy_mid", int'(busy), 1);
      if (y_v) begin
        cnt++;
        ycyc = c;
      end
      tick();
    end
    sample_en = 1'b0;
    check_output("overrun_yv_count", cnt, 1);
    check_output("overrun_yv_cycle", ycyc, LAT);
    check_output("overrun_flag", int'(overrun), 1);
    check_output("overrun_y", int'(y), 500);
    apply_reset();
    check_output("overrun_cleared", int'(overrun), 0);
    check_output("y_cleared", int'(y), 0);

    $display("[TB] frame_v during computation");
    apply_frame(-2048, 1'b1, 100, 1024);
    apply_sample(yv, lat);
    check_output("shadow_y0", yv, 1024);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    apply_frame(0, 1'b1, 100, 1024);
    wait_y(yv, lat);
    check_output("shadow_old_a1", yv, 512);
    apply_sample(yv, lat);
    check_output("shadow_new_a1", yv, 0);

    $display("[TB] noise excitation");
    apply_reset();
    apply_frame(0, 1'b0, 50, 4000);
    lfsr = 16'hACE1;
    for (int n = 0; n < 6; n++) begin
      apply_sample(yv, lat);
      check_output($sformatf("noise_y%0d", n), yv, lfsr[0] ? 1000 : -1000);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) rst = 1'b1;
      if (y_v) cnt++;
      tick();
    end
    check_output("reset_mid_mac_no_yv", cnt, 0);
    apply_frame(0, 1'b0, 50, 4000);
    apply_sample(yv, lat);
    check_output("noise_restart_y0", yv, 1000);
    apply_sample(yv, lat);
    check_output("noise_restart_y1", yv, -1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
